iscas_serdes_harness: RTL

Parametrised pin-multiplexing harness placed between the 8-bit io_in/io_out pads and any ISCAS89 benchmark netlist whose PI/PO count exceeds the pads.
- Deserialises a primary-input vector from LANES-bit beats and applies it to the benchmark.
- Issues exactly one benchmark step strobe, waits a settle window, then captures the primary outputs.
- Serialises the captured PO vector back out with a valid/ready handshake.
- Supersedes the fixed one-benchmark-per-pad top: the top-level becomes benchmark-agnostic.

---
 rtl/iscas_harness_pkg.sv | 29 ++
 rtl/iscas_lane_shreg.sv | 49 ++++
 rtl/iscas_serdes_harness.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/iscas_harness_pkg.sv
// Shared definitions for the ISCAS89 serialising pad harness.
//   state_e  : harness sequencing states, LOAD through UNLOAD
//   ceil_div : integer ceiling division, used to size beat counts
//   beat_w   : counter width able to hold 0..beats-1, never below 1
package iscas_harness_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_STEP    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_UNLOAD  = 3'd5
    } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int beat_w(input int beats);
        int w;
        w = 1;
        while ((1 << w) < beats) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/iscas_lane_shreg.sv
// Lane-wide shift register shared by the PI and PO sides of the harness.
// Shifting moves the contents down by LANES bits and inserts shift_in_i at
// the top, so beats entered LSB-first end up in order at the bottom, and
// the bottom LANES bits are always the next beat to send.
//   clk_i, rst_i  : clock and synchronous active-high reset
//   load_i        : parallel load of load_data_i (wins over shift_i)
//   shift_i       : shift down by one beat, inserting shift_in_i on top
//   q_o           : current register contents
//   shift_next_o  : value the register takes if shifted this cycle
module iscas_lane_shreg #(
    parameter int WIDTH = 4,
    parameter int LANES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic [LANES-1:0] shift_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] shift_next_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shifted;

    // A single-beat register has nothing left to shift down.
    generate
        if (WIDTH > LANES) begin : g_multi
            assign shifted = {shift_in_i, shreg_q[WIDTH-1:LANES]};
        end else begin : g_single
            assign shifted = shift_in_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= load_data_i;
        end else if (shift_i) begin
            shreg_q <= shifted;
        end
    end

    assign q_o          = shreg_q;
    assign shift_next_o = shifted;

endmodule

// File: rtl/iscas_serdes_harness.sv
// Pin-multiplexing harness between narrow pads and an ISCAS89 benchmark.
// A PI vector arrives as LANES-bit beats, is applied to the benchmark, one
// step strobe is issued, the POs are captured after SETTLE idle cycles and
// then returned as LANES-bit beats under a valid/ready handshake.
//   CK, RST               : clock and synchronous active-high reset
//   in_data/valid/ready   : PI beat stream in, LSB-first
//   out_data/valid/ready  : PO beat stream out, LSB-first, zero-padded
//   dut_pi, dut_step      : registered PI vector and one-cycle step strobe
//   dut_po                : benchmark primary outputs
//   busy, step_count      : not-in-LOAD flag and completed-step counter
module iscas_serdes_harness
    import iscas_harness_pkg::*;
#(
    parameter int NUM_PI = 3,
    parameter int NUM_PO = 6,
    parameter int LANES  = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic              CK,
    input  logic              RST,
    input  logic [LANES-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANES-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_PI-1:0] dut_pi,
    output logic              dut_step,
    input  logic [NUM_PO-1:0] dut_po,
    output logic              busy,
    output logic [CNT_W-1:0]  step_count
);

    localparam int BEATS_IN  = ceil_div(NUM_PI, LANES);
    localparam int BEATS_OUT = ceil_div(NUM_PO, LANES);
    localparam int PIW       = BEATS_IN * LANES;
    localparam int POW       = BEATS_OUT * LANES;
    localparam int BIW       = beat_w(BEATS_IN);
    localparam int BOW       = beat_w(BEATS_OUT);

    localparam logic [BIW-1:0] LAST_IN     = BIW'(BEATS_IN - 1);
    localparam logic [BOW-1:0] LAST_OUT    = BOW'(BEATS_OUT - 1);
    localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [BIW-1:0]      beat_in_q, beat_in_d;
    logic [BOW-1:0]      beat_out_q, beat_out_d;
    logic [3:0]          settle_q, settle_d;
    logic [NUM_PI-1:0]   dut_pi_q, dut_pi_d;
    logic [CNT_W-1:0]    step_count_q, step_count_d;

    logic                pi_accept;
    logic                po_load;
    logic                po_shift;
    logic [PIW-1:0]      pi_q;
    logic [PIW-1:0]      pi_next;
    logic [POW-1:0]      po_q;
    logic [POW-1:0]      po_next;
    logic                unused_ok;

    assign pi_accept = in_valid && (state_q == ST_LOAD);
    assign po_load   = (state_q == ST_CAPTURE);
    assign po_shift  = out_ready && (state_q == ST_UNLOAD);

    iscas_lane_shreg #(
        .WIDTH (PIW),
        .LANES (LANES)
    ) u_pi_shreg (
        .clk_i        (CK),
        .rst_i        (RST),
        .load_i       (1'b0),
        .load_data_i  ('0),
        .shift_i      (pi_accept),
        .shift_in_i   (in_data),
        .q_o          (pi_q),
        .shift_next_o (pi_next)
    );

    // The PO vector is zero-extended to whole beats so padding bits read 0.
    iscas_lane_shreg #(
        .WIDTH (POW),
        .LANES (LANES)
    ) u_po_shreg (
        .clk_i        (CK),
        .rst_i        (RST),
        .load_i       (po_load),
        .load_data_i  (POW'(dut_po)),
        .shift_i      (po_shift),
        .shift_in_i   ('0),
        .q_o          (po_q),
        .shift_next_o (po_next)
    );

    // Only the low beat of the PO register and the shifted PI value are
    // consumed; the rest is folded here so nothing reads as dangling.
    assign unused_ok = ^{pi_q, po_next, po_q};

    // Sequencing: the final PI beat loads dut_pi using the shifted value of
    // the same edge, so the vector is on the pins the very next cycle.
    always_comb begin
        state_d      = state_q;
        beat_in_d    = beat_in_q;
        beat_out_d   = beat_out_q;
        settle_d     = settle_q;
        dut_pi_d     = dut_pi_q;
        step_count_d = step_count_q;
        case (state_q)
            ST_LOAD: begin
                if (pi_accept) begin
                    if (beat_in_q == LAST_IN) begin
                        beat_in_d = '0;
                        dut_pi_d  = pi_next[NUM_PI-1:0];
                        state_d   = ST_APPLY;
                    end else begin
                        beat_in_d = beat_in_q + BIW'(1);
                    end
                end
            end
            ST_APPLY: begin
                state_d = ST_STEP;
            end
            ST_STEP: begin
                settle_d = '0;
                state_d  = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                step_count_d = step_count_q + CNT_W'(1);
                state_d      = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    if (beat_out_q == LAST_OUT) begin
                        beat_out_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        beat_out_d = beat_out_q + BOW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q      <= ST_LOAD;
            beat_in_q    <= '0;
            beat_out_q   <= '0;
            settle_q     <= '0;
            dut_pi_q     <= '0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_in_q    <= beat_in_d;
            beat_out_q   <= beat_out_d;
            settle_q     <= settle_d;
            dut_pi_q     <= dut_pi_d;
            step_count_q <= step_count_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_LOAD);
    assign dut_step   = (state_q == ST_STEP);
    assign out_valid  = (state_q == ST_UNLOAD);
    assign out_data   = po_q[LANES-1:0];
    assign dut_pi     = dut_pi_q;
    assign step_count = step_count_q;

endmodule
